// File: rtl/kbd_ascii_fifo.sv
// kbd_ascii_fifo: consumes PS/2 set-2 scancodes from the receiver over the
// data_ready/rdn handshake, tracks break/extended prefixes and shift state,
// translates make codes to ASCII and queues them in a show-ahead FIFO.
module kbd_ascii_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       data_ready,
  input  logic [7:0] scancode,
  output logic       rdn,
  input  logic       rd_en,
  output logic [7:0] ascii,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACK      = 2'b01,
    WAIT_CLR = 2'b10
  } state_t;

  state_t            state_r;
  logic [7:0]        code_r;
  logic              brk_r;
  logic              ext_r;
  logic              lshift_r;
  logic              rshift_r;
  logic              rdn_r;

  logic [7:0]        mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [7:0]        ascii_r;
  logic              empty_r;
  logic              full_r;
  logic              overflow_r;

  logic [8:0]        lookup_s;
  logic              push_s;
  logic [7:0]        push_data_s;
  logic              pop_ok_s;
  logic              push_ok_s;
  logic              ovf_set_s;
  logic [AW-1:0]     wr_ptr_nxt_s;
  logic [AW-1:0]     rd_ptr_nxt_s;
  logic [AW:0]       count_nxt_s;
  logic [7:0]        ascii_nxt_s;

  // Set-2 make code to ASCII; bit 8 flags a mapped code.
  function automatic logic [8:0] code_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] base;
    logic [8:0] res;
    base = shift ? 8'h41 : 8'h61;
    case (code)
      8'h1C: res = {1'b1, base + 8'd0};
      8'h32: res = {1'b1, base + 8'd1};
      8'h21: res = {1'b1, base + 8'd2};
      8'h23: res = {1'b1, base + 8'd3};
      8'h24: res = {1'b1, base + 8'd4};
      8'h2B: res = {1'b1, base + 8'd5};
      8'h34: res = {1'b1, base + 8'd6};
      8'h33: res = {1'b1, base + 8'd7};
      8'h43: res = {1'b1, base + 8'd8};
      8'h3B: res = {1'b1, base + 8'd9};
      8'h42: res = {1'b1, base + 8'd10};
      8'h4B: res = {1'b1, base + 8'd11};
      8'h3A: res = {1'b1, base + 8'd12};
      8'h31: res = {1'b1, base + 8'd13};
      8'h44: res = {1'b1, base + 8'd14};
      8'h4D: res = {1'b1, base + 8'd15};
      8'h15: res = {1'b1, base + 8'd16};
      8'h2D: res = {1'b1, base + 8'd17};
      8'h1B: res = {1'b1, base + 8'd18};
      8'h2C: res = {1'b1, base + 8'd19};
      8'h3C: res = {1'b1, base + 8'd20};
      8'h2A: res = {1'b1, base + 8'd21};
      8'h1D: res = {1'b1, base + 8'd22};
      8'h22: res = {1'b1, base + 8'd23};
      8'h35: res = {1'b1, base + 8'd24};
      8'h1A: res = {1'b1, base + 8'd25};
      8'h45: res = {1'b1, 8'h30};
      8'h16: res = {1'b1, 8'h31};
      8'h1E: res = {1'b1, 8'h32};
      8'h26: res = {1'b1, 8'h33};
      8'h25: res = {1'b1, 8'h34};
      8'h2E: res = {1'b1, 8'h35};
      8'h36: res = {1'b1, 8'h36};
      8'h3D: res = {1'b1, 8'h37};
      8'h3E: res = {1'b1, 8'h38};
      8'h46: res = {1'b1, 8'h39};
      8'h29: res = {1'b1, 8'h20};
      8'h5A: res = {1'b1, 8'h0D};
      8'h66: res = {1'b1, 8'h08};
      default: res = {1'b0, 8'h00};
    endcase
    return res;
  endfunction

  // Decode the latched byte during ACK: only an unprefixed, mapped make code pushes.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = 8'h00;
    lookup_s    = code_to_ascii(code_r, lshift_r | rshift_r);
    if ((state_r == ACK) && !brk_r && !ext_r &&
        (code_r != 8'hF0) && (code_r != 8'hE0) &&
        (code_r != 8'h12) && (code_r != 8'h59) && lookup_s[8]) begin
      push_s      = 1'b1;
      push_data_s = lookup_s[7:0];
    end else begin
      push_s      = 1'b0;
      push_data_s = 8'h00;
    end
  end

  // FIFO next-state: pop needs data, push into a full FIFO needs a same-cycle pop.
  always_comb begin
    pop_ok_s     = rd_en && (count_r != {(AW+1){1'b0}});
    push_ok_s    = push_s && ((count_r != FULL_CNT) || pop_ok_s);
    ovf_set_s    = push_s && (count_r == FULL_CNT) && !pop_ok_s;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    ascii_nxt_s  = 8'h00;
    if (push_ok_s) begin
      wr_ptr_nxt_s = wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
    // The next head may be the entry being written this very cycle.
    if (count_nxt_s == {(AW+1){1'b0}}) begin
      ascii_nxt_s = 8'h00;
    end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      ascii_nxt_s = push_data_s;
    end else begin
      ascii_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Handshake FSM with prefix/shift tracking and registered rdn pulse.
  always_ff @(posedge fclk) begin
    if (!rst) begin
      state_r  <= IDLE;
      code_r   <= 8'h00;
      brk_r    <= 1'b0;
      ext_r    <= 1'b0;
      lshift_r <= 1'b0;
      rshift_r <= 1'b0;
      rdn_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (data_ready) begin
            code_r  <= scancode;
            rdn_r   <= 1'b1;
            state_r <= ACK;
          end else begin
            rdn_r   <= 1'b0;
          end
        end
        ACK: begin
          rdn_r   <= 1'b0;
          state_r <= WAIT_CLR;
          if (code_r == 8'hF0) begin
            brk_r <= 1'b1;
          end else if (code_r == 8'hE0) begin
            ext_r <= 1'b1;
          end else if (code_r == 8'h12) begin
            lshift_r <= ~brk_r;
            brk_r    <= 1'b0;
            ext_r    <= 1'b0;
          end else if (code_r == 8'h59) begin
            rshift_r <= ~brk_r;
            brk_r    <= 1'b0;
            ext_r    <= 1'b0;
          end else begin
            brk_r <= 1'b0;
            ext_r <= 1'b0;
          end
        end
        WAIT_CLR: begin
          rdn_r <= 1'b0;
          if (!data_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_CLR;
          end
        end
        default: begin
          rdn_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge fclk) begin
    if (rst && push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // FIFO pointers, count, registered status/head and sticky overflow.
  always_ff @(posedge fclk) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      ascii_r    <= 8'h00;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      ascii_r    <= ascii_nxt_s;
      empty_r    <= (count_nxt_s == {(AW+1){1'b0}});
      full_r     <= (count_nxt_s == FULL_CNT);
      overflow_r <= overflow_r | ovf_set_s;
    end
  end

  assign rdn      = rdn_r;
  assign ascii    = ascii_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Directed bench for kbd_ascii_fifo: acts as the scancode receiver and the CPU.
module tb_kbd_ascii_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic       fclk = 1'b0;
  logic       rst = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       rdn;
  logic       rd_en = 1'b0;
  logic [7:0] ascii;
  logic       empty;
  logic       full;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int rdn_cnt = 0;
  int snap;

  kbd_ascii_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .fclk(fclk), .rst(rst), .data_ready(data_ready), .scancode(scancode),
    .rdn(rdn), .rd_en(rd_en), .ascii(ascii), .empty(empty), .full(full),
    .overflow(overflow)
  );

  always #5 fclk = ~fclk;

  // Count rdn pulses, sampled away from the active edge.
  always @(negedge fclk) begin
    if (rdn === 1'b1) rdn_cnt <= rdn_cnt + 1;
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the rdn pulse; returns at the negedge where rdn=1.
  task automatic wait_rdn(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge fclk);
      if (rdn === 1'b1) seen = 1'b1;
    end
    if (!seen) chk(tag, 9'd0, 9'd1);
  endtask

  // Present one byte like the receiver; optionally pop in the push cycle.
  task automatic send(input logic [7:0] code, input logic pop_same);
    scancode   = code;
    data_ready = 1'b1;
    wait_rdn("rdn_timeout");
    data_ready = 1'b0;
    scancode   = 8'h00;
    rd_en      = pop_same;
    @(negedge fclk);
    rd_en = 1'b0;
    @(negedge fclk);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge fclk);
    rd_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {1'b0, ascii}, {1'b0, exp});
    pop();
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    repeat (2) @(negedge fclk);
    chk("rst_rdn", {8'h00, rdn}, 9'd0);
    chk("rst_empty", {8'h00, empty}, 9'd1);
    chk("rst_full", {8'h00, full}, 9'd0);
    chk("rst_ovf", {8'h00, overflow}, 9'd0);
    chk("rst_ascii", {1'b0, ascii}, 9'h000);
    rst = 1'b1;
    @(negedge fclk);

    // Single key
    snap = rdn_cnt;
    send(8'h1C, 1'b0);
    chk("single_rdn", 9'(rdn_cnt - snap), 9'd1);
    chk("single_empty", {8'h00, empty}, 9'd0);
    pop_chk("single_ascii", 8'h61);
    chk("single_empty_after", {8'h00, empty}, 9'd1);
    chk("single_ascii_after", {1'b0, ascii}, 9'h000);

    // Make/break with shift
    send(8'h12, 1'b0); send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h12, 1'b0); send(8'h1C, 1'b0);
    pop_chk("shift_A", 8'h41);
    pop_chk("shift_a", 8'h61);
    chk("shift_empty", {8'h00, empty}, 9'd1);

    // Extended and unmapped codes
    snap = rdn_cnt;
    send(8'hE0, 1'b0); send(8'h75, 1'b0); send(8'hE0, 1'b0); send(8'hF0, 1'b0);
    send(8'h75, 1'b0); send(8'h0E, 1'b0); send(8'h16, 1'b0);
    chk("ext_rdn7", 9'(rdn_cnt - snap), 9'd7);
    pop_chk("ext_one", 8'h31);
    chk("ext_empty", {8'h00, empty}, 9'd1);

    // Push with pop while empty: push only
    send(8'h29, 1'b1);
    chk("emp_pp_empty", {8'h00, empty}, 9'd0);
    pop_chk("emp_pp_ascii", 8'h20);
    chk("emp_pp_empty2", {8'h00, empty}, 9'd1);

    // Overflow
    for (int i = 0; i < DEPTH; i++) send(8'h45, 1'b0);
    chk("fill_full", {8'h00, full}, 9'd1);
    chk("fill_ovf0", {8'h00, overflow}, 9'd0);
    send(8'h45, 1'b0);
    chk("ovf_set", {8'h00, overflow}, 9'd1);
    chk("ovf_full", {8'h00, full}, 9'd1);
    send(8'h29, 1'b1);
    chk("pp_full", {8'h00, full}, 9'd1);
    chk("pp_ovf", {8'h00, overflow}, 9'd1);
    for (int i = 0; i < DEPTH - 1; i++) pop_chk("drain_30", 8'h30);
    pop_chk("drain_20", 8'h20);
    chk("drain_empty", {8'h00, empty}, 9'd1);
    chk("drain_ovf_sticky", {8'h00, overflow}, 9'd1);

    // Held data_ready: one consume only
    snap = rdn_cnt;
    scancode   = 8'h1C;
    data_ready = 1'b1;
    wait_rdn("held_timeout");
    repeat (10) @(negedge fclk);
    chk("held_rdn", 9'(rdn_cnt - snap), 9'd1);
    chk("held_empty", {8'h00, empty}, 9'd0);
    data_ready = 1'b0;
    repeat (2) @(negedge fclk);
    pop_chk("held_ascii", 8'h61);
    chk("held_one_entry", {8'h00, empty}, 9'd1);
    send(8'h16, 1'b0);
    pop_chk("held_next", 8'h31);

    // Reset during ACK aborts; byte still presented is consumed as new
    scancode   = 8'h1C;
    data_ready = 1'b1;
    wait_rdn("ackrst_timeout");
    rst = 1'b0;
    @(negedge fclk);
    chk("ackrst_rdn", {8'h00, rdn}, 9'd0);
    chk("ackrst_empty", {8'h00, empty}, 9'd1);
    chk("ackrst_ovf", {8'h00, overflow}, 9'd0);
    rst = 1'b1;
    wait_rdn("ackrst_new_timeout");
    data_ready = 1'b0;
    repeat (2) @(negedge fclk);
    pop_chk("ackrst_new", 8'h61);
    chk("ackrst_final_empty", {8'h00, empty}, 9'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
